// File: rtl/handshake_pkg.sv
// Shared defaults and output-buffer state encoding for the handshake arbiter.
package handshake_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ID_W_DEF   = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/handshake_arb_rr_pick.sv
// Round-robin search: first set request at or above ptr_i, wrapping past N-1 to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] pos_s;

    // Walk the requests in priority order starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[pos_s]) begin
                any_o          = 1'b1;
                grant_o[pos_s] = 1'b1;
                idx_o          = pos_s;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/handshake_arb.sv
// N-to-1 valid/ready arbiter with round-robin fairness and a one-entry registered output buffer.
module handshake_arb
    import handshake_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        s_valid,
    input  logic [N_REQ*DATA_W-1:0] s_data,
    output logic [N_REQ-1:0]        s_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic [ID_W-1:0]         m_id,
    input  logic                    m_ready
);

    buf_state_e        state_q;
    logic [DATA_W-1:0] m_data_q;
    logic [ID_W-1:0]   m_id_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;

    logic [N_REQ-1:0]  win_grant_s;
    logic [ID_W-1:0]   win_idx_s;
    logic              win_any_s;
    logic              accept_en_s;
    logic              accept_s;
    logic [DATA_W-1:0] win_data_s;

    rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .req_i   (s_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_grant_s),
        .idx_o   (win_idx_s),
        .any_o   (win_any_s)
    );

    // The buffer can take a new word when empty or when it drains in this same cycle.
    always_comb begin
        accept_en_s = !rst && ((state_q == ST_EMPTY) || m_ready);
        accept_s    = accept_en_s && win_any_s;
        win_data_s  = s_data[win_idx_s*DATA_W +: DATA_W];
        if (accept_en_s) begin
            s_ready = win_grant_s;
        end else begin
            s_ready = '0;
        end
        if (win_idx_s == ID_W'(N_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = win_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
        end
    end

    // Buffer state, payload register and fairness pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            m_id_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) state_q <= ST_FULL;
                    else          state_q <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (accept_s)     state_q <= ST_FULL;
                    else if (m_ready) state_q <= ST_EMPTY;
                    else              state_q <= ST_FULL;
                end
                default: state_q <= ST_EMPTY;
            endcase
            if (accept_s) begin
                m_data_q <= win_data_s;
                m_id_q   <= win_idx_s;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign m_valid = (state_q == ST_FULL);
    assign m_data  = m_data_q;
    assign m_id    = m_id_q;

endmodule

// File: doc/handshake_arb.md
HANDSHAKE_ARB -- requirements
Module: handshake_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of upstream requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per requester.
REQ-003 SHALL have parameter ID_W, default 2, equal to clog2(N_REQ).
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 s_valid  input  N_REQ  per-requester valid; bit i belongs to requester i.
REQ-007 s_data  input  N_REQ*DATA_W  payloads; requester i owns bits [i*DATA_W +: DATA_W].
REQ-008 s_ready  output  N_REQ  per-requester ready; at most one bit high per cycle.
REQ-009 m_valid  output  1  registered valid toward the shared receiver.
REQ-010 m_data  output  DATA_W  registered payload toward the shared receiver.
REQ-011 m_id  output  ID_W  registered index of the requester that sourced m_data.
REQ-012 m_ready  input  1  receiver ready.

Function
REQ-013 SHALL hold a one-entry output buffer; states EMPTY (m_valid=0) and FULL (m_valid=1).
REQ-014 Transfer on side i SHALL occur when s_valid[i] and s_ready[i] are both high at a rising edge; on the master side when m_valid and m_ready are both high.
REQ-015 accept_en SHALL be (EMPTY) or (FULL and m_ready); s_ready is combinational from s_valid, pointer and accept_en.
REQ-016 s_ready[i] SHALL be high only when accept_en is high and requester i is the round-robin winner; s_ready SHALL be all-zero when no s_valid bit is set.
REQ-017 Winner SHALL be the first set s_valid bit searching upward from index rr_ptr, wrapping N_REQ-1 -> 0.
REQ-018 On each upstream transfer, rr_ptr SHALL become (winner+1) mod N_REQ; otherwise rr_ptr holds.
REQ-019 On upstream transfer, m_data and m_id SHALL load the winner's payload and index and m_valid SHALL be 1 on the next cycle (latency 1).
REQ-020 In FULL with m_ready low, m_valid, m_data and m_id SHALL hold stable and s_ready SHALL be all-zero.
REQ-021 In FULL with m_ready high and a pending s_valid, drain and accept SHALL occur in the same cycle; the buffer stays FULL with the new payload (one transfer per cycle sustained).
REQ-022 In FULL with m_ready high and no s_valid, the buffer SHALL go EMPTY.
REQ-023 A requester dropping s_valid before acceptance SHALL lose no state; it re-enters arbitration next time it asserts.
REQ-024 With all N_REQ requesters continuously valid and m_ready high, each SHALL be granted exactly once per N_REQ consecutive transfers.

Reset
REQ-025 While rst is high at a rising edge: m_valid=0, m_data=0, m_id=0, rr_ptr=0, state EMPTY.
REQ-026 While rst is high, s_ready SHALL be all-zero, regardless of s_valid.
REQ-027 Reset asserted while FULL SHALL discard the buffered payload without an m_valid/m_ready transfer.

Structure
REQ-028 A shared package handshake_pkg SHALL hold the N_REQ/DATA_W/ID_W defaults and the EMPTY/FULL state encoding.
REQ-029 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: one-hot grant, index, any).
REQ-030 No latches; all outputs except s_ready SHALL be driven from flops.

Verification
REQ-031 Reset then s_valid=4'b0100, s_data[2]=8'hA5, m_ready=1 -> s_ready=4'b0100 that cycle; next cycle m_valid=1, m_data=8'hA5, m_id=2.
REQ-032 s_valid=4'b1111 held, m_ready=1 for 8 cycles from rr_ptr=0 -> m_id sequence 0,1,2,3,0,1,2,3, one transfer per cycle.
REQ-033 Buffer FULL with m_data=8'h11, m_ready=0 for 5 cycles while s_valid=4'b0011 -> m_data/m_id stable, s_ready=0 throughout.
REQ-034 rr_ptr=3, s_valid=4'b0001 -> wrap-around grant to 0, rr_ptr becomes 1.
REQ-035 rst pulsed for 1 cycle while FULL with m_ready=0 -> next cycle m_valid=0, m_id=0, rr_ptr=0; no m_valid/m_ready transfer observed.
REQ-036 Random s_valid/m_ready over 10000 cycles -> scoreboard: every accepted payload appears exactly once, in order, with correct m_id; s_ready never multi-hot.
